gray_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit binary-to-Gray conversion datapath among N_REQ requesters. It grants one requester at a time and registers that requester's Gray-coded result into a single output slot. The slot drains through a valid/ready handshake. The block sits between the lab's code-converter datapath and the clients that need Gray-coded values, such as counter and pointer-synchronisation logic.

---
 rtl/gray_conv_arbiter.sv | 106 ++++++++++
 tb/tb_gray_conv_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter among N_REQ requesters.
// The winner's Gray-coded word lands in a single output slot drained by valid/ready.
module gray_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*WIDTH-1:0] bin_in,
    input  logic                   ready_in,
    output logic [N_REQ-1:0]       gnt_out,
    output logic [WIDTH-1:0]       gray_out,
    output logic [ID_W-1:0]        id_out,
    output logic                   valid_out,
    output logic [7:0]             conv_cnt_out
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   gray_q, gray_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               arb_en;
    logic               found;
    logic [ID_W-1:0]    win_idx;
    logic [N_REQ-1:0]   eligible;
    logic [WIDTH-1:0]   win_bin;
    logic               xfer;

    // The requester granted last cycle still shows its stale request; mask it.
    assign eligible = req_in & ~gnt_q;
    assign xfer     = (state_q == StFull) && ready_in;
    assign arb_en   = (state_q == StEmpty) || ready_in;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % int'(N_REQ);
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = ID_W'(idx);
            end
        end
    end

    assign win_bin = bin_in[int'(win_idx)*int'(WIDTH) +: WIDTH];

    always_comb begin
        int nxt;
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        gray_d  = gray_q;
        id_d    = id_q;
        cnt_d   = xfer ? cnt_q + 8'd1 : cnt_q;
        nxt     = (int'(win_idx) + 1) % int'(N_REQ);

        unique case (state_q)
            StEmpty, StFull: begin
                if (arb_en && found) begin
                    state_d          = StFull;
                    gnt_d[win_idx]   = 1'b1;
                    gray_d           = win_bin ^ (win_bin >> 1);
                    id_d             = win_idx;
                    ptr_d            = ID_W'(nxt);
                end else if (xfer) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            gnt_q   <= '0;
            gray_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            gray_q  <= gray_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_out      = gnt_q;
    assign gray_out     = gray_q;
    assign id_out       = id_q;
    assign valid_out    = (state_q == StFull);
    assign conv_cnt_out = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: grants, Gray values, backpressure, reset, counter wrap.
module tb_gray_conv_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned ID_W  = 2;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic [N_REQ-1:0]       req_in;
    logic [N_REQ*WIDTH-1:0] bin_in;
    logic                   ready_in;
    logic [N_REQ-1:0]       gnt_out;
    logic [WIDTH-1:0]       gray_out;
    logic [ID_W-1:0]        id_out;
    logic                   valid_out;
    logic [7:0]             conv_cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    gray_conv_arbiter #(
        .N_REQ(N_REQ),
        .WIDTH(WIDTH),
        .ID_W (ID_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_in      (req_in),
        .bin_in      (bin_in),
        .ready_in    (ready_in),
        .gnt_out     (gnt_out),
        .gray_out    (gray_out),
        .id_out      (id_out),
        .valid_out   (valid_out),
        .conv_cnt_out(conv_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " gnt"},   32'(gnt_out), 32'h0);
        check({tag, " gray"},  32'(gray_out), 32'h0);
        check({tag, " id"},    32'(id_out), 32'h0);
        check({tag, " valid"}, 32'(valid_out), 32'h0);
        check({tag, " cnt"},   32'(conv_cnt_out), 32'h0);
    endtask

    logic [3:0] exp_gray4 [4];

    initial begin
        rst_in   = 1'b1;
        req_in   = '0;
        bin_in   = '0;
        ready_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        check_reset_vals("reset");

        // Single requester
        req_in        = 4'b0010;
        bin_in[7:4]   = 4'b1011;
        step();
        check("single gnt",   32'(gnt_out), 32'b0010);
        check("single gray",  32'(gray_out), 32'b1110);
        check("single id",    32'(id_out), 32'd1);
        check("single valid", 32'(valid_out), 32'd1);
        req_in = '0;
        step();
        check("single drained", 32'(valid_out), 32'd0);
        check("single cnt",     32'(conv_cnt_out), 32'd1);
        check("single gray hold", 32'(gray_out), 32'b1110);

        // All four from reset
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("rst2 cnt", 32'(conv_cnt_out), 32'd0);
        bin_in       = {4'hC, 4'h9, 4'h6, 4'h3};
        exp_gray4[0] = 4'h2;
        exp_gray4[1] = 4'h5;
        exp_gray4[2] = 4'hD;
        exp_gray4[3] = 4'hA;
        req_in = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr%0d gnt", k),  32'(gnt_out), 32'(1 << k));
            check($sformatf("rr%0d id", k),   32'(id_out), 32'(k));
            check($sformatf("rr%0d gray", k), 32'(gray_out), 32'(exp_gray4[k]));
            req_in[k] = 1'b0;
        end
        step();
        check("rr drained", 32'(valid_out), 32'd0);
        check("rr cnt",     32'(conv_cnt_out), 32'd4);

        // Fairness: pointer has wrapped to 0, so 0 wins first
        req_in = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("fair%0d gnt", k), 32'(gnt_out), (k % 2 == 0) ? 32'b0001 : 32'b0010);
        end
        req_in = '0;
        step();
        check("fair cnt", 32'(conv_cnt_out), 32'd8);

        // Backpressure: slot FULL with id 2
        bin_in      = '0;
        bin_in[11:8] = 4'b0111;
        req_in      = 4'b0100;
        step();
        check("bp gnt2", 32'(gnt_out), 32'b0100);
        check("bp gray2", 32'(gray_out), 32'b0100);
        req_in   = 4'b1011;
        bin_in   = '1;
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp%0d gnt", k),   32'(gnt_out), 32'h0);
            check($sformatf("bp%0d id", k),    32'(id_out), 32'd2);
            check($sformatf("bp%0d gray", k),  32'(gray_out), 32'b0100);
            check($sformatf("bp%0d valid", k), 32'(valid_out), 32'd1);
        end
        check("bp cnt frozen", 32'(conv_cnt_out), 32'd8);
        ready_in = 1'b1;
        step();
        check("bp next gnt",  32'(gnt_out), 32'b1000);
        check("bp next id",   32'(id_out), 32'd3);
        check("bp next gray", 32'(gray_out), 32'b1000);
        check("bp cnt",       32'(conv_cnt_out), 32'd9);
        req_in = 4'b0011;
        step();
        check("bp then gnt", 32'(gnt_out), 32'b0001);
        check("bp then id",  32'(id_out), 32'd0);
        check("bp then cnt", 32'(conv_cnt_out), 32'd10);

        // Reset mid-operation while FULL
        req_in = 4'b1111;
        rst_in = 1'b1;
        step();
        check_reset_vals("midrst");
        rst_in = 1'b0;
        step();
        check("post rst gnt", 32'(gnt_out), 32'b0001);
        check("post rst id",  32'(id_out), 32'd0);

        // Counter wrap: continuous grants with ready high
        for (int k = 0; k < 255; k++) step();
        check("wrap 255", 32'(conv_cnt_out), 32'd255);
        check("wrap valid", 32'(valid_out), 32'd1);
        step();
        check("wrap 0", 32'(conv_cnt_out), 32'd0);
        req_in = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
